// File: rtl/y86_pkg.sv
// Shared Y86 definitions: status codes, icodes, register IDs and the writeback status FSM state type.
// Used by writeback_regfile (optional retire counter: Y86_RETIRE_CNT_EN).
package y86_pkg;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [1:0] {
        WB_RUN   = 2'd0,
        WB_HALT  = 2'd1,
        WB_FAULT = 2'd2
    } wb_state_t;

    // Undefined status encodings (0, 5..7) are folded into INS.
    function automatic logic [2:0] normalize_stat(input logic [2:0] stat);
        logic [2:0] result;
        case (stat)
            STAT_AOK, STAT_HLT, STAT_ADR, STAT_INS: result = stat;
            default:                                result = STAT_INS;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/wb_stat_fsm.sv
// Program status tracker for the writeback stage: RUN until a processed HLT or fault,
// then terminal until reset. All outputs are registered.
module wb_stat_fsm
    import y86_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       proc_valid,
    input  logic [2:0] w_stat,
    output wb_state_t  state,
    output logic [2:0] prog_stat,
    output logic       halted
);

    logic [2:0] stat_n_s;

    assign stat_n_s = normalize_stat(w_stat);

    // Status state machine with registered prog_stat/halted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= WB_RUN;
            prog_stat <= STAT_AOK;
            halted    <= 1'b0;
        end else begin
            case (state)
                WB_RUN: begin
                    if (proc_valid) begin
                        case (stat_n_s)
                            STAT_AOK: begin
                                state     <= WB_RUN;
                                prog_stat <= STAT_AOK;
                                halted    <= 1'b0;
                            end
                            STAT_HLT: begin
                                state     <= WB_HALT;
                                prog_stat <= STAT_HLT;
                                halted    <= 1'b1;
                            end
                            default: begin
                                state     <= WB_FAULT;
                                prog_stat <= stat_n_s;
                                halted    <= 1'b1;
                            end
                        endcase
                    end else begin
                        state     <= WB_RUN;
                        prog_stat <= STAT_AOK;
                        halted    <= 1'b0;
                    end
                end
                WB_HALT: begin
                    state     <= WB_HALT;
                    prog_stat <= STAT_HLT;
                    halted    <= 1'b1;
                end
                WB_FAULT: begin
                    state     <= WB_FAULT;
                    prog_stat <= prog_stat;
                    halted    <= 1'b1;
                end
                default: begin
                    // Unreachable encoding: stop the program rather than resume.
                    state     <= WB_FAULT;
                    prog_stat <= STAT_INS;
                    halted    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/writeback_regfile.sv
// Y86 register file and retirement point fed by the W pipeline register.
// Define Y86_RETIRE_CNT_EN to add the retire_cnt port and retired-instruction counter.
module writeback_regfile
    import y86_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int NREG   = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              W_stall,
    input  logic [2:0]        W_stat,
    input  logic [3:0]        W_icode,
    input  logic [DATA_W-1:0] W_valE,
    input  logic [DATA_W-1:0] W_valM,
    input  logic [3:0]        W_dstE,
    input  logic [3:0]        W_dstM,
    input  logic [3:0]        d_srcA,
    input  logic [3:0]        d_srcB,
    output logic [DATA_W-1:0] d_rvalA,
    output logic [DATA_W-1:0] d_rvalB,
    output logic [2:0]        prog_stat,
    output logic              halted
`ifdef Y86_RETIRE_CNT_EN
    ,
    output logic [63:0]       retire_cnt
`endif
);

    logic              w_new_r;
    wb_state_t         state_s;
    logic              proc_valid_s;
    logic              commit_s;
    logic              wr_e_s;
    logic              wr_m_s;
    logic [DATA_W-1:0] regs_r [NREG];

    // W freshness: a stalled W must be processed only once
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_new_r <= 1'b0;
        end else begin
            w_new_r <= ~W_stall;
        end
    end

    assign proc_valid_s = w_new_r && (state_s == WB_RUN);
    assign commit_s     = proc_valid_s && (W_stat == STAT_AOK);
    assign wr_e_s       = commit_s && (W_dstE != RNONE);
    assign wr_m_s       = commit_s && (W_dstM != RNONE);

    wb_stat_fsm u_stat_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .proc_valid (proc_valid_s),
        .w_stat     (W_stat),
        .state      (state_s),
        .prog_stat  (prog_stat),
        .halted     (halted)
    );

    // Register array write; the M port has priority when both target one register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 32'sd0; i < NREG; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 32'sd0; i < NREG; i++) begin
                if (wr_m_s && (W_dstM == 4'(i))) begin
                    regs_r[i] <= W_valM;
                end else if (wr_e_s && (W_dstE == 4'(i))) begin
                    regs_r[i] <= W_valE;
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end
    end

    // Decode read ports: pre-edge contents, RNONE and out-of-range IDs read zero
    always_comb begin
        d_rvalA = {DATA_W{1'b0}};
        d_rvalB = {DATA_W{1'b0}};
        for (int i = 32'sd0; i < NREG; i++) begin
            if ((d_srcA == 4'(i)) && (d_srcA != RNONE)) begin
                d_rvalA = regs_r[i];
            end else begin
                d_rvalA = d_rvalA;
            end
            if ((d_srcB == 4'(i)) && (d_srcB != RNONE)) begin
                d_rvalB = regs_r[i];
            end else begin
                d_rvalB = d_rvalB;
            end
        end
    end

`ifdef Y86_RETIRE_CNT_EN
    // Retired-instruction count: AOK instructions other than NOP, wraps at 2^64
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retire_cnt <= 64'd0;
        end else if (commit_s && (W_icode != I_NOP)) begin
            retire_cnt <= retire_cnt + 64'd1;
        end else begin
            retire_cnt <= retire_cnt;
        end
    end
`else
    logic unused_icode_s;
    assign unused_icode_s = ^W_icode;
`endif

endmodule

// File: tb/tb_writeback_regfile.sv
// Self-checking bench for writeback_regfile: directed table, an all-registers sequence,
// and randomized traffic checked against a behavioural model.
module tb_writeback_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        W_stall;
    logic [2:0]  W_stat;
    logic [3:0]  W_icode;
    logic [63:0] W_valE, W_valM;
    logic [3:0]  W_dstE, W_dstM;
    logic [3:0]  d_srcA, d_srcB;
    logic [63:0] d_rvalA, d_rvalB;
    logic [2:0]  prog_stat;
    logic        halted;
    logic [63:0] retire_cnt;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    writeback_regfile dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .W_stall    (W_stall),
        .W_stat     (W_stat),
        .W_icode    (W_icode),
        .W_valE     (W_valE),
        .W_valM     (W_valM),
        .W_dstE     (W_dstE),
        .W_dstM     (W_dstM),
        .d_srcA     (d_srcA),
        .d_srcB     (d_srcB),
        .d_rvalA    (d_rvalA),
        .d_rvalB    (d_rvalB),
        .prog_stat  (prog_stat),
        .halted     (halted)
`ifdef Y86_RETIRE_CNT_EN
        ,
        .retire_cnt (retire_cnt)
`endif
    );

`ifndef Y86_RETIRE_CNT_EN
    assign retire_cnt = 64'd0;
`endif

    // Behavioural model: program state 0=running 1=halted 2=faulted
    logic [63:0] m_regs [15];
    int          m_state;
    logic [2:0]  m_code;
    bit          m_new;
    logic [63:0] m_cnt;

    function automatic logic [63:0] m_read(input logic [3:0] id);
        return (id < 4'd15) ? m_regs[id] : 64'd0;
    endfunction

    task automatic model_edge();
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) m_regs[i] = 64'd0;
            m_state = 0; m_code = 3'd1; m_new = 1'b0; m_cnt = 64'd0;
        end else begin
            if (m_new && m_state == 0) begin
                if (W_stat == 3'd1) begin
                    if (W_dstE != 4'hF) m_regs[W_dstE] = W_valE;
                    if (W_dstM != 4'hF) m_regs[W_dstM] = W_valM;
                    if (W_icode != 4'h1) m_cnt = m_cnt + 64'd1;
                end else if (W_stat == 3'd2) begin
                    m_state = 1;
                end else begin
                    m_state = 2;
                    m_code  = (W_stat == 3'd3) ? 3'd3 : 3'd4;
                end
            end
            m_new = !W_stall;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_w(input logic rst, input logic stall, input logic [2:0] stat,
                         input logic [3:0] icode, input logic [63:0] ve, input logic [63:0] vm,
                         input logic [3:0] de, input logic [3:0] dm,
                         input logic [3:0] sa, input logic [3:0] sb);
        rst_n = rst; W_stall = stall; W_stat = stat; W_icode = icode;
        W_valE = ve; W_valM = vm; W_dstE = de; W_dstM = dm; d_srcA = sa; d_srcB = sb;
    endtask

    typedef struct {
        logic        rst;
        logic        stall;
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [63:0] ve, vm;
        logic [3:0]  de, dm, sa, sb;
        logic [63:0] ea, eb;
        logic [2:0]  estat;
        logic        ehalt;
        logic [63:0] ecnt;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic stall, input logic [2:0] stat,
                                input logic [3:0] icode, input logic [63:0] ve, input logic [63:0] vm,
                                input logic [3:0] de, input logic [3:0] dm,
                                input logic [3:0] sa, input logic [3:0] sb,
                                input logic [63:0] ea, input logic [63:0] eb,
                                input logic [2:0] estat, input logic ehalt, input logic [63:0] ecnt);
        vec_t v;
        v.rst = rst; v.stall = stall; v.stat = stat; v.icode = icode; v.ve = ve; v.vm = vm;
        v.de = de; v.dm = dm; v.sa = sa; v.sb = sb; v.ea = ea; v.eb = eb;
        v.estat = estat; v.ehalt = ehalt; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic check_outputs(input string tag, input logic [63:0] ea, input logic [63:0] eb,
                                 input logic [2:0] es, input logic eh, input logic [63:0] ec);
        chk({tag, ".rvalA"}, d_rvalA, ea);
        chk({tag, ".rvalB"}, d_rvalB, eb);
        chk({tag, ".prog_stat"}, {61'd0, prog_stat}, {61'd0, es});
        chk({tag, ".halted"}, {63'd0, halted}, {63'd0, eh});
`ifdef Y86_RETIRE_CNT_EN
        chk({tag, ".retire_cnt"}, retire_cnt, ec);
`endif
    endtask

    vec_t tbl [22];

    initial begin
        tbl[0]  = mk(0,0,3'd1,4'h1,64'h0, 64'h0, 4'hF,4'hF,4'h3,4'h3, 64'h0, 64'h0, 3'd1,0,64'd0);
        tbl[1]  = mk(1,0,3'd1,4'h6,64'h5, 64'h0, 4'h3,4'hF,4'h3,4'h3, 64'h0, 64'h0, 3'd1,0,64'd0);
        tbl[2]  = mk(1,0,3'd1,4'h6,64'h5, 64'h0, 4'h3,4'hF,4'h3,4'h3, 64'h5, 64'h5, 3'd1,0,64'd1);
        tbl[3]  = mk(1,0,3'd1,4'h5,64'h10,64'h20,4'h4,4'h4,4'h4,4'h3, 64'h20,64'h5, 3'd1,0,64'd2);
        tbl[4]  = mk(1,1,3'd1,4'h3,64'h77,64'h0, 4'h1,4'hF,4'h1,4'h4, 64'h77,64'h20,3'd1,0,64'd3);
        for (int k = 5; k <= 8; k++)
            tbl[k] = mk(1,1,3'd1,4'h3,64'h99,64'h0,4'h1,4'hF,4'h1,4'h4, 64'h77,64'h20,3'd1,0,64'd3);
        tbl[9]  = mk(1,0,3'd1,4'h1,64'h0, 64'h0, 4'hF,4'hF,4'h1,4'h4, 64'h77,64'h20,3'd1,0,64'd3);
        tbl[10] = mk(1,0,3'd1,4'h1,64'h0, 64'h0, 4'hF,4'hF,4'h1,4'h4, 64'h77,64'h20,3'd1,0,64'd3);
        tbl[11] = mk(1,0,3'd2,4'h0,64'h0, 64'h0, 4'hF,4'hF,4'h1,4'h2, 64'h77,64'h0, 3'd2,1,64'd3);
        tbl[12] = mk(1,0,3'd1,4'h3,64'h55,64'h0, 4'h2,4'hF,4'h2,4'h1, 64'h0, 64'h77,3'd2,1,64'd3);
        tbl[13] = mk(1,0,3'd1,4'h3,64'h55,64'h0, 4'h2,4'hF,4'h2,4'h1, 64'h0, 64'h77,3'd2,1,64'd3);
        tbl[14] = mk(0,0,3'd1,4'h3,64'h55,64'h0, 4'h2,4'hF,4'h2,4'h4, 64'h0, 64'h0, 3'd1,0,64'd0);
        tbl[15] = mk(1,0,3'd3,4'h5,64'hAB,64'h0, 4'h5,4'hF,4'h5,4'h1, 64'h0, 64'h0, 3'd1,0,64'd0);
        tbl[16] = mk(1,0,3'd3,4'h5,64'hAB,64'h0, 4'h5,4'hF,4'h5,4'h1, 64'h0, 64'h0, 3'd3,1,64'd0);
        tbl[17] = mk(1,0,3'd1,4'h3,64'h1, 64'h0, 4'h5,4'hF,4'h5,4'h1, 64'h0, 64'h0, 3'd3,1,64'd0);
        tbl[18] = mk(0,0,3'd1,4'h3,64'h1, 64'h0, 4'h5,4'hF,4'h5,4'h1, 64'h0, 64'h0, 3'd1,0,64'd0);
        tbl[19] = mk(1,0,3'd6,4'h1,64'h0, 64'h0, 4'hF,4'hF,4'h5,4'h1, 64'h0, 64'h0, 3'd1,0,64'd0);
        tbl[20] = mk(1,0,3'd6,4'h1,64'h0, 64'h0, 4'hF,4'hF,4'h5,4'h1, 64'h0, 64'h0, 3'd4,1,64'd0);
        tbl[21] = mk(0,0,3'd1,4'h1,64'h0, 64'h0, 4'hF,4'hF,4'h5,4'h1, 64'h0, 64'h0, 3'd1,0,64'd0);

        // Directed table: each row is one cycle, checked just after its closing edge
        for (int k = 0; k < 22; k++) begin
            set_w(tbl[k].rst, tbl[k].stall, tbl[k].stat, tbl[k].icode, tbl[k].ve, tbl[k].vm,
                  tbl[k].de, tbl[k].dm, tbl[k].sa, tbl[k].sb);
            tick();
            check_outputs($sformatf("row%0d", k), tbl[k].ea, tbl[k].eb, tbl[k].estat,
                          tbl[k].ehalt, tbl[k].ecnt);
        end

        // Write every register, then probe RNONE, reg14 and all IDs
        set_w(0,0,3'd1,4'h1,64'h0,64'h0,4'hF,4'hF,4'hF,4'hF);
        tick();
        set_w(1,0,3'd1,4'h1,64'h0,64'h0,4'hF,4'hF,4'hF,4'hF);
        tick();
        for (int i = 0; i < 15; i++) begin
            set_w(1,0,3'd1,4'h3,64'h1000 + 64'(i),64'h0,4'(i),4'hF,4'hF,4'hF);
            tick();
        end
        set_w(1,0,3'd1,4'h1,64'h0,64'h0,4'hF,4'hF,4'hF,4'hF);
        tick();
        d_srcB = 4'hF; #1;
        chk("all.srcB_F", d_rvalB, 64'h0);
        d_srcB = 4'hE; #1;
        chk("all.srcB_E", d_rvalB, 64'h100E);
        for (int i = 0; i < 15; i++) begin
            d_srcA = 4'(i); #1;
            chk($sformatf("all.reg%0d", i), d_rvalA, 64'h1000 + 64'(i));
        end
`ifdef Y86_RETIRE_CNT_EN
        chk("all.retire_cnt", retire_cnt, 64'd15);
`endif

        // Randomized traffic against the model
        set_w(0,0,3'd1,4'h1,64'h0,64'h0,4'hF,4'hF,4'h0,4'h0);
        tick();
        for (int c = 0; c < 800; c++) begin
            int r;
            logic [2:0] st;
            r = int'($urandom_range(0, 99));
            if (r < 92)      st = 3'd1;
            else if (r < 95) st = 3'd2;
            else if (r < 97) st = 3'd3;
            else             st = 3'($urandom_range(0, 7));
            set_w((m_state != 0) ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 60) != 0),
                  ($urandom_range(0, 3) == 0), st, 4'($urandom_range(0, 11)),
                  {$urandom, $urandom}, {$urandom, $urandom},
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            tick();
            check_outputs($sformatf("rnd%0d", c), m_read(d_srcA), m_read(d_srcB),
                          (m_state == 0) ? 3'd1 : ((m_state == 1) ? 3'd2 : m_code),
                          (m_state != 0), m_cnt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/writeback_regfile.md
# writeback_regfile

Register-file and retirement block at the consumer end of the W pipeline register. Each cycle it takes the instruction held in W, commits `W_valE`/`W_valM` to the Y86 program registers, and tracks program status (AOK/HLT/ADR/INS). It serves the decode-stage read ports, and it signals halt/fault to the pipeline control logic.

## Interface
- `DATA_W`, 64, register and value width
- `NREG`, 15, number of program registers (IDs 0..14); ID 4'hF is RNONE
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `W_stall`  in  3-bit-free 1  same W_stall driven to the W register; high means W holds its contents at the next edge
- `W_stat`  in  3  status of the instruction in W
- `W_icode`  in  4  icode in W
- `W_valE`, `W_valM`  in  64  result values in W
- `W_dstE`, `W_dstM`  in  4  destination IDs (RNONE = no write)
- `d_srcA`, `d_srcB`  in  4  decode read IDs
- `d_rvalA`, `d_rvalB`  out  64  read data
- `prog_stat`  out  3  architectural status
- `halted`  out  1  high once the program has stopped (HLT or fault)
- `retire_cnt`  out  64  retired-instruction count (only with the macro)

## Operation
- `w_new_q` tracks whether the W contents are new; reset 0; at every edge `w_new_q <= ~W_stall`.
- The instruction in W is *processed* only in a cycle where `w_new_q==1 && state==RUN`. This means stalled contents are processed once, never twice.
- Processing rules:
  - If `W_stat==AOK`, write `W_valE` to `W_dstE` and `W_valM` to `W_dstM`.
  - A write whose ID is RNONE is dropped.
  - If `W_dstE==W_dstM` and the ID is not RNONE, `W_valM` wins.
  - If `W_stat!=AOK`, no register is written.
- Status FSM, states RUN, HALT, FAULT:
  - RUN→HALT when a processed `W_stat==HLT`.
  - RUN→FAULT when a processed `W_stat` is ADR or INS; the fault code is latched.
  - A processed stat of 0 or 5-7 is treated as INS.
  - HALT and FAULT are terminal until reset; no writes and no counting occur in them.
- `prog_stat`: AOK in RUN, HLT in HALT, the latched code in FAULT. `halted = (state!=RUN)`.
- Reads are combinational from the array.
  - RNONE or an ID ≥ NREG reads 0.
  - Reads see the pre-edge contents: no write-through bypass. Decode forwarding from W covers the same-cycle case.

## Timing
- Register write latency: 1 edge. A value processed in cycle t is readable at `d_rval*` in cycle t+1.
- The FSM transition takes effect at the edge ending the processing cycle. `halted` is high in the next cycle.
- Reset (synchronous, checked every edge, also mid-run or while halted):
  - all registers = 0
  - state = RUN, `prog_stat` = AOK (3'd1), `halted` = 0
  - `w_new_q` = 0
  - `retire_cnt` = 0
- First cycle after reset: W contents are ignored because `w_new_q==0`.
- W_stall held high for N cycles: exactly one processing event, in the cycle after the edge that loaded W.

## Configuration
- Macro `Y86_RETIRE_CNT_EN`.
- Defined:
  - `retire_cnt` port exists.
  - The count increments by 1 per processed instruction with `W_stat==AOK` and `W_icode!=NOP(4'h1)`.
  - A HLT instruction is not counted.
  - The count wraps modulo 2^64.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package `y86_pkg`:
  - stat codes AOK=1, HLT=2, ADR=3, INS=4
  - icodes (HALT=0, NOP=1, …)
  - RNONE=4'hF
  - FSM state enum `wb_state_t`
- Natural sub-module: `wb_stat_fsm`. It takes the processed-valid flag and `W_stat`, and produces state, `prog_stat` and `halted`. The register array and read muxes stay in the top level.

## Test plan
- Reset, then W = {AOK, OPQ, valE=0x5, dstE=3, dstM=F}, `W_stall`=0 for 2 cycles → `d_srcA=3` reads 0x5 from cycle 2. With the macro, `retire_cnt`=1.
- W = {AOK, MRMOVQ/POPQ-style, dstE=4, dstM=4, valE=0x10, valM=0x20} → reg4 = 0x20.
- Hold W = {AOK, IRMOVQ, dstE=1} with `W_stall`=1 for 5 cycles → reg1 is written once and `retire_cnt` increments by exactly 1.
- W = {HLT, HALT} → `halted`=1 and `prog_stat`=2 next cycle. Subsequent AOK writes to reg2 are ignored, and reg2 stays 0.
- W = {ADR, dstE=5} → reg5 unchanged, `prog_stat`=3. Then assert `rst_n`=0 for 1 cycle → `prog_stat`=1, `halted`=0, all reads 0.
- Read `d_srcB`=F or 4'hE after writing every register → `d_rvalB`=0 for F and the reg14 value for E.
